// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: restoring division, one quotient bit per cycle, borrowing the shared ALU.
// Latency: done pulses WORD_LEN+4 cycles after start is sampled (1 cycle for divide-by-zero / signed overflow).
// Backpressure: busy stalls EX from start until done inclusive; start is ignored while busy, flush aborts silently.
// Ports: clk/rst (sync, active-high), start/op/a/b request, flush abort, busy/done/result status,
//        alu_sel/alu_a/alu_b/alu_ctrl drive the EX operand mux, alu_out is the shared ALU result (same cycle).
module div_sequencer #(
  parameter int         WORD_LEN      = 32,
  parameter logic [3:0] ALU_CTRL_SUB  = 4'b0001,
  parameter logic [3:0] ALU_CTRL_ZERO = 4'b0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WORD_LEN-1:0] a,
  input  logic [WORD_LEN-1:0] b,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] result,
  output logic                alu_sel,
  output logic [WORD_LEN-1:0] alu_a,
  output logic [WORD_LEN-1:0] alu_b,
  output logic [3:0]          alu_ctrl,
  input  logic [WORD_LEN-1:0] alu_out
);

  localparam int CW = $clog2(WORD_LEN);
  localparam logic [WORD_LEN-1:0] INT_MIN = {1'b1, {(WORD_LEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_NEGA, S_NEGB, S_ITER, S_FIX, S_DONE
  } state_t;

  state_t              state;
  logic [WORD_LEN-1:0] dvd;      // dividend, shifted into the quotient during ITER
  logic [WORD_LEN-1:0] dvs;      // divisor magnitude
  logic [WORD_LEN-1:0] rem;      // partial remainder
  logic [CW-1:0]       cnt;
  logic                sgn;
  logic                neg_q;
  logic                neg_r;
  logic                want_rem;

  // Per-iteration trial subtract: the bit shifted out of rem (cout) means the
  // shifted value already exceeds any W-bit divisor, so unsigned operands with
  // the top bit set keep full precision.
  logic [WORD_LEN-1:0] shifted;
  logic                ge;
  logic [WORD_LEN-1:0] fix_sel;
  logic                fix_neg;

  assign shifted = {rem[WORD_LEN-2:0], dvd[WORD_LEN-1]};
  assign ge      = rem[WORD_LEN-1] | (shifted >= dvs);
  assign fix_sel = want_rem ? rem : dvd;
  assign fix_neg = want_rem ? neg_r : neg_q;

  // ALU operands are a pure decode of registered state: the ALU answers in the
  // same cycle, so registering them would cost an extra cycle per step.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_CTRL_ZERO;
    case (state)
      S_NEGA: begin alu_ctrl = ALU_CTRL_SUB; alu_b = dvd; end
      S_NEGB: begin alu_ctrl = ALU_CTRL_SUB; alu_b = dvs; end
      S_ITER: begin alu_ctrl = ALU_CTRL_SUB; alu_a = shifted; alu_b = dvs; end
      S_FIX:  begin alu_ctrl = ALU_CTRL_SUB; alu_b = fix_sel; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      alu_sel  <= 1'b0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      sgn      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
    end else if (flush) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_sel <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd      <= a;
            dvs      <= b;
            rem      <= '0;
            want_rem <= op[1];
            sgn      <= ~op[0];
            neg_q    <= ~op[0] & (a[WORD_LEN-1] ^ b[WORD_LEN-1]);
            neg_r    <= ~op[0] & a[WORD_LEN-1];
            busy     <= 1'b1;
            if (b == '0) begin
              result <= op[1] ? a : '1;
              done   <= 1'b1;
              state  <= S_DONE;
            end else if (~op[0] && (a == INT_MIN) && (b == '1)) begin
              result <= op[1] ? '0 : a;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              alu_sel <= 1'b1;
              state   <= S_NEGA;
            end
          end
        end
        S_NEGA: begin
          if (sgn && dvd[WORD_LEN-1]) dvd <= alu_out;
          state <= S_NEGB;
        end
        S_NEGB: begin
          if (sgn && dvs[WORD_LEN-1]) dvs <= alu_out;
          cnt   <= CW'(WORD_LEN - 1);
          state <= S_ITER;
        end
        S_ITER: begin
          rem <= ge ? alu_out : shifted;
          dvd <= {dvd[WORD_LEN-2:0], ge};
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          result  <= fix_neg ? alu_out : fix_sel;
          alu_sel <= 1'b0;
          done    <= 1'b1;
          state   <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
